// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with valid/ready handshake and tag pass-through.
module muldiv_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  op1,
   input  logic [XLEN-1:0]  op2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int unsigned     CW   = $clog2(XLEN);
   localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   m_q, m_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [TAG_W-1:0]  tag_q, tag_d;

   logic              accept, s1, s2, special;
   logic [XLEN-1:0]   a_mag, b_mag, spec_val, diff, step_hi, step_lo, fix;
   logic [XLEN:0]     mul_sum, div_tmp;
   logic [2*XLEN-1:0] prod;

   assign in_ready  = rst_n && !flush &&
                      (state_q == IDLE || (state_q == DONE && out_ready));
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;
   assign out_tag   = tag_q;

   always_comb begin
      accept   = in_valid && in_ready;
      s1       = op1[XLEN-1] && (funct3 == 3'b001 || funct3 == 3'b010 ||
                                 funct3 == 3'b100 || funct3 == 3'b110);
      s2       = op2[XLEN-1] && (funct3 == 3'b001 || funct3 == 3'b100 ||
                                 funct3 == 3'b110);
      a_mag    = s1 ? -op1 : op1;
      b_mag    = s2 ? -op2 : op2;
      special  = 1'b0;
      spec_val = '0;
      if (funct3[2] && op2 == '0) begin
         special  = 1'b1;
         spec_val = funct3[1] ? op1 : '1;
      end else if (!funct3[0] && funct3[2] && op1 == MINV && op2 == '1) begin
         special  = 1'b1;
         spec_val = funct3[1] ? '0 : op1;
      end

      // Multiply keeps the multiplicand in m and shifts the product right through {hi,lo};
      // divide keeps the divisor in m and shifts the dividend left out of lo into hi.
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      div_tmp = {hi_q, lo_q[XLEN-1]};
      diff    = div_tmp[XLEN-1:0] - m_q;
      if (op_q[2]) begin
         if (div_tmp >= {1'b0, m_q}) begin
            step_hi = diff;
            step_lo = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            step_hi = div_tmp[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
      end

      prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
      if (op_q[2])
         fix = op_q[1] ? (neg_q ? -step_hi : step_hi) : (neg_q ? -step_lo : step_lo);
      else
         fix = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      m_d      = m_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      tag_d    = tag_q;

      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            BUSY: begin
               hi_d  = step_hi;
               lo_d  = step_lo;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  result_d = fix;
                  state_d  = DONE;
               end
            end
            DONE:    if (out_ready) state_d = IDLE;
            default: ;
         endcase

         if (accept) begin
            op_d  = funct3;
            tag_d = in_tag;
            cnt_d = '0;
            hi_d  = '0;
            // REM follows the dividend's sign; MUL*/DIV follow the sign mismatch.
            neg_d = (funct3 == 3'b110) ? s1 : (s1 ^ s2);
            m_d   = funct3[2] ? b_mag : a_mag;
            lo_d  = funct3[2] ? a_mag : b_mag;
            if (special) begin
               result_d = spec_val;
               state_d  = DONE;
            end else begin
               state_d = BUSY;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         m_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         m_q      <= m_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
         tag_q    <= tag_d;
      end
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide unit; multi-cycle companion to the single-cycle integer ALU in the execute stage.
- Takes funct3-encoded M-extension ops and returns results through a valid/ready handshake.
- Width is parametrised by XLEN.
- Supports flush, back-pressure and a destination-register tag pass-through.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- TAG_W, 5, width of the pass-through destination tag.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  abort any in-flight op and drop any held result.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1  in  XLEN  rs1 value.
- op2  in  XLEN  rs2 value.
- in_tag  in  TAG_W  destination register tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  op result.
- out_tag  out  TAG_W  tag captured with the accepted request.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset (rst_n low, async) forces:
  - state to IDLE;
  - out_valid=0, busy=0, result=0, out_tag=0;
  - iteration counter and internal registers to 0.
  - in_ready goes high after reset deasserts.
- State machine has three states: IDLE, BUSY, DONE.
- Handshakes:
  - in_ready = (state==IDLE) || (state==DONE && out_ready); in_ready is 0 while flush is high.
  - Accept = in_valid && in_ready at a rising edge. On accept, capture funct3, operand magnitudes, sign flags and in_tag.
  - out_valid = (state==DONE).
  - A result, once valid, holds stable (result, out_tag) until out_valid && out_ready.
  - A pop and a new accept in the same cycle are legal: DONE goes to BUSY (or to DONE for special cases), with no bubble.
- Normal operation:
  - Accept moves IDLE to BUSY with count=0.
  - BUSY performs one radix-2 step per cycle and increments count.
  - At the edge that completes step XLEN-1, sign fix-up is applied, result is registered, and the state moves to DONE.
  - Latency: out_valid is high XLEN edges after the accepting edge, i.e. 32 for XLEN=32.
  - DONE with out_ready moves to IDLE, or to BUSY if a new op is accepted in the same cycle.
- Special cases bypass BUSY and enter DONE on the accepting edge, so out_valid is high 1 edge later:
  - op2==0, DIV/DIVU: result = all ones.
  - op2==0, REM/REMU: result = op1.
  - DIV with op1 = most-negative and op2 = -1: result = op1.
  - REM with op1 = most-negative and op2 = -1: result = 0.
- Arithmetic:
  - Multiply: unsigned shift-add of operand magnitudes into a 2*XLEN product.
    - MUL returns the low XLEN bits.
    - MULH, MULHSU and MULHU return the high XLEN bits.
    - Signedness: MULH treats both operands as signed. MULHSU treats op1 as signed and op2 as unsigned. MULHU treats both as unsigned.
    - The product is negated if the operand signs differ, counting only signed operands.
  - Divide: restoring division on magnitudes.
    - DIV/DIVU quotient is truncated toward zero and negated if the operand signs differ (DIV only).
    - REM/REMU remainder takes the sign of op1 (REM only).
  - All arithmetic is modulo 2^XLEN (or 2^(2*XLEN) for the product); no exceptions are raised.
- Flush:
  - When flush is high at an edge, the state goes to IDLE and out_valid drops next cycle; any held result is discarded.
  - Flush has priority over accept and pop in the same cycle.
- Reset mid-operation behaves as a flush plus clearing of all outputs.
- Changes on in_valid, funct3 or operands after the accepting edge are ignored.

Test Plan:
- XLEN=32, MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 32 edges after accept, out_tag equals in_tag.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with out_valid 1 edge after accept:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIVU 5/0 -> 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> result and out_tag stable, in_ready=0.
  - Then raise out_ready with in_valid=1 -> pop and accept on the same edge; the second result arrives 32 edges later.
- Flush and reset:
  - Assert flush 10 cycles into BUSY -> IDLE next cycle, out_valid never asserts, in_ready=1.
  - Repeat with rst_n pulsed low mid-BUSY -> all outputs 0 immediately, without waiting for a clock edge.
